cache_sram_ctrl: RTL

- Sequencer and arbiter in front of the per-core cache tag/data/state SRAM (`cache_sram`).
- After reset it sweeps every line's state to INVALID, replacing the missing reset on the state file.
- It then shares the single read port and single write port between two requesters: requester 0 is the core-side pipeline, requester 1 is the snoop/coherence path.
- Each port has its own round-robin arbitration. A same-cycle write to the index being read is forwarded into the read response.

---
 rtl/cache_sram_ctrl_pkg.sv | 35 +++
 rtl/cache_rr_arbiter.sv | 33 +++
 rtl/cache_sram_ctrl.sv | 123 ++++++++++++
 3 files changed

// File: rtl/cache_sram_ctrl_pkg.sv
// Shared types for the cache SRAM sequencer/arbiter.
// Line geometry, coherence states and controller FSM encoding.
package cache_sram_ctrl_pkg;

  localparam int INDEX_W = 9;
  localparam int TAG_W   = 20;
  localparam int LINE_W  = 32;

  typedef logic [INDEX_W-1:0] addr_index;
  typedef logic [TAG_W-1:0]   addr_tag;
  typedef logic [LINE_W-1:0]  line;

  typedef enum logic [1:0] {
    INVALID   = 2'd0,
    SHARED    = 2'd1,
    EXCLUSIVE = 2'd2,
    MODIFIED  = 2'd3
  } line_state;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ctrl_state_e;

  localparam int DEPTH = 1 << $bits(addr_index);

  typedef struct packed {
    logic      data_en;
    logic      state_en;
    addr_tag   tag;
    line       data;
    line_state state;
  } fwd_t;

endpackage

// File: rtl/cache_rr_arbiter.sv
// Two-way round-robin arbiter with a registered last-grant bit.
// Reset leaves requester 1 as last winner so requester 0 wins first.
module cache_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic last_q, last_d;

  always_comb begin
    grant  = 2'b00;
    last_d = last_q;
    if (en) begin
      unique case (valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = last_q ? 2'b01 : 2'b10;
        default: grant = 2'b00;
      endcase
    end
    if (grant[1]) last_d = 1'b1;
    else if (grant[0]) last_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end

endmodule

// File: rtl/cache_sram_ctrl.sv
// Init sweep plus read/write port arbitration for the cache SRAM.
// Same-cycle writes to the read index are forwarded into the response.
module cache_sram_ctrl
  import cache_sram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic      [1:0]       rd_valid,
  input  addr_index [1:0]       rd_index,
  output logic      [1:0]       rd_ready,
  output logic      [1:0]       rd_resp_valid,
  output addr_tag               rd_tag,
  output line                   rd_data,
  output line_state             rd_state,
  input  logic      [1:0]       wr_valid,
  input  addr_index [1:0]       wr_index,
  input  logic      [1:0]       wr_data_en,
  input  logic      [1:0]       wr_state_en,
  input  addr_tag   [1:0]       wr_tag,
  input  line       [1:0]       wr_data,
  input  line_state [1:0]       wr_state,
  output logic      [1:0]       wr_ready,
  output logic                  init_done,
  output addr_index             sram_index_rd,
  output addr_index             sram_index_wr,
  output logic                  sram_write_data,
  output logic                  sram_write_state,
  output addr_tag               sram_tag_wr,
  output line                   sram_data_wr,
  output line_state             sram_state_wr,
  input  addr_tag               sram_tag_rd,
  input  line                   sram_data_rd,
  input  line_state             sram_state_rd
);

  ctrl_state_e state_q, state_d;
  addr_index   cnt_q, cnt_d;
  logic        init_done_q, init_done_d;
  logic [1:0]  resp_q, resp_d;
  fwd_t        fwd_q, fwd_d;

  logic [1:0] rd_gnt, wr_gnt;
  logic       rd_g, wr_g, run, hit;

  assign run  = (state_q == RUN);
  assign rd_g = rd_gnt[1];
  assign wr_g = wr_gnt[1];

  cache_rr_arbiter u_rd_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .valid (rd_valid),
    .grant (rd_gnt)
  );

  cache_rr_arbiter u_wr_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (run),
    .valid (wr_valid),
    .grant (wr_gnt)
  );

  assign hit = (|rd_gnt) && (|wr_gnt) &&
               (rd_index[rd_g] == wr_index[wr_g]);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (state_q == INIT) begin
      cnt_d = cnt_q + addr_index'(1);
      if (cnt_q == addr_index'(DEPTH - 1)) begin
        state_d     = RUN;
        init_done_d = 1'b1;
      end
    end
    resp_d         = rd_gnt;
    fwd_d.data_en  = hit & wr_data_en[wr_g];
    fwd_d.state_en = hit & wr_state_en[wr_g];
    fwd_d.tag      = wr_tag[wr_g];
    fwd_d.data     = wr_data[wr_g];
    fwd_d.state    = wr_state[wr_g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      resp_q      <= 2'b00;
      fwd_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
      resp_q      <= resp_d;
      fwd_q       <= fwd_d;
    end
  end

  assign rd_ready      = rd_gnt;
  assign wr_ready      = wr_gnt;
  assign rd_resp_valid = resp_q;
  assign init_done     = init_done_q;

  assign sram_index_rd = rd_index[rd_g];
  assign sram_index_wr = run ? wr_index[wr_g] : cnt_q;

  assign sram_write_data  = (|wr_gnt) & wr_data_en[wr_g];
  assign sram_write_state = run ? ((|wr_gnt) & wr_state_en[wr_g])
                                : 1'b1;
  assign sram_tag_wr      = wr_tag[wr_g];
  assign sram_data_wr     = wr_data[wr_g];
  assign sram_state_wr    = run ? wr_state[wr_g] : INVALID;

  // Response fields come from the forwarded write only where enabled.
  assign rd_tag   = fwd_q.data_en  ? fwd_q.tag   : sram_tag_rd;
  assign rd_data  = fwd_q.data_en  ? fwd_q.data  : sram_data_rd;
  assign rd_state = fwd_q.state_en ? fwd_q.state : sram_state_rd;

endmodule
